accel_tilt_filter: RTL and testbench



---
 rtl/accel_pkg.sv | 34 +++
 rtl/tilt_axis_filter.sv | 125 ++++++++++++
 rtl/accel_tilt_filter.sv | 136 +++++++++++++
 tb/tb_accel_tilt_filter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerometer tilt filter:
//   - DATA_W / OUT_W default widths (raw sample, output tilt)
//   - state_e : calibration / running state of the shared FSM
//   - saturate(): clamps a DATA_W+1 bit signed value into OUT_W bits signed
// -----------------------------------------------------------------------------
package accel_pkg;

  localparam int DATA_W = 12;
  localparam int OUT_W  = 8;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } state_e;

  // Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The input width matches the
  // offset-corrected difference (DATA_W+1 bits).
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [DATA_W:0] v);
    logic signed [DATA_W:0] hi;
    logic signed [DATA_W:0] lo;
    hi = (DATA_W+1)'((1 << (OUT_W-1)) - 1);
    lo = ~hi;  // two's complement: ~max == min
    if (v > hi) begin
      return hi[OUT_W-1:0];
    end else if (v < lo) begin
      return lo[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tilt_axis_filter.sv
// -----------------------------------------------------------------------------
// tilt_axis_filter
// Per-axis datapath: calibration accumulator and offset, sliding-window
// history with running sum, and the registered output stage
// (average -> offset removal -> scale -> optional dead zone -> saturate).
// Optional feature macro: ACCEL_TILT_DEADZONE_EN (enables the dead zone).
//
// Ports:
//   CLK, rst_n     clock, asynchronous active-low reset
//   i_sample       raw signed sample for this axis
//   i_calibrate    clears calibration sum, history, running sum and tilt
//   i_cal_acc      accumulate i_sample into the calibration sum
//   i_cal_last     with i_cal_acc: this is the final sample, latch the offset
//   i_run_acc      push i_sample into the window and update the running sum
//   i_load         register a new tilt from the current running sum
//   o_tilt         filtered, saturated signed tilt
// -----------------------------------------------------------------------------
module tilt_axis_filter
  import accel_pkg::*;
#(
  parameter int DATA_W   = accel_pkg::DATA_W,
  parameter int OUT_W    = accel_pkg::OUT_W,
  parameter int AVG_LOG2 = 3,
  parameter int CAL_LOG2 = 4,
  parameter int DEADZONE = 2
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_calibrate,
  input  logic                     i_cal_acc,
  input  logic                     i_cal_last,
  input  logic                     i_run_acc,
  input  logic                     i_load,
  output logic signed [OUT_W-1:0]  o_tilt
);

  localparam int CS_W  = DATA_W + CAL_LOG2;
  localparam int RS_W  = DATA_W + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SHIFT = DATA_W - OUT_W;
  localparam logic signed [DATA_W:0] DZ = (DATA_W+1)'(DEADZONE);
`ifdef ACCEL_TILT_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic signed [CS_W-1:0]   cal_sum_q, cal_sum_d, cal_sum_next;
  logic signed [DATA_W-1:0] offset_q, offset_d;
  logic signed [DATA_W-1:0] hist_q [DEPTH];
  logic [AVG_LOG2-1:0]      wr_ptr_q;
  logic signed [RS_W-1:0]   run_sum_q, run_sum_d;
  logic signed [OUT_W-1:0]  tilt_q, tilt_d;

  logic signed [DATA_W-1:0] avg;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W:0]   t_shift;
  logic signed [DATA_W:0]   t_dz;

  always_comb begin
    cal_sum_next = cal_sum_q + CS_W'(i_sample);
    cal_sum_d    = cal_sum_q;
    offset_d     = offset_q;
    run_sum_d    = run_sum_q;
    tilt_d       = tilt_q;

    if (i_calibrate) begin
      cal_sum_d = '0;
    end else if (i_cal_acc) begin
      if (i_cal_last) begin
        cal_sum_d = '0;
        offset_d  = DATA_W'(cal_sum_next >>> CAL_LOG2);
      end else begin
        cal_sum_d = cal_sum_next;
      end
    end

    // History starts zeroed, so the running sum is exact once the window fills.
    if (i_calibrate) begin
      run_sum_d = '0;
    end else if (i_run_acc) begin
      run_sum_d = run_sum_q + RS_W'(i_sample) - RS_W'(hist_q[wr_ptr_q]);
    end

    // Output stage works from the registered running sum (one cycle after the
    // sample), which puts the new tilt two cycles after the strobe.
    avg     = DATA_W'(run_sum_q >>> AVG_LOG2);
    diff    = (DATA_W+1)'(avg) - (DATA_W+1)'(offset_q);
    t_shift = diff >>> SHIFT;
    t_dz    = (DZ_EN && (t_shift <= DZ) && (t_shift >= -DZ)) ? '0 : t_shift;

    if (i_calibrate) begin
      tilt_d = '0;
    end else if (i_load) begin
      tilt_d = saturate(t_dz);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cal_sum_q <= '0;
      offset_q  <= '0;
      run_sum_q <= '0;
      tilt_q    <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      cal_sum_q <= cal_sum_d;
      offset_q  <= offset_d;
      run_sum_q <= run_sum_d;
      tilt_q    <= tilt_d;
      if (i_calibrate) begin
        wr_ptr_q <= '0;
        for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      end else if (i_run_acc) begin
        hist_q[wr_ptr_q] <= i_sample;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
    end
  end

  assign o_tilt = tilt_q;

endmodule

// File: rtl/accel_tilt_filter.sv
// -----------------------------------------------------------------------------
// accel_tilt_filter
// Conditions raw accelerometer X/Y samples into 8-bit signed tilt: captures a
// resting offset during calibration, then moving-averages each axis, removes
// the offset, scales, applies an optional dead zone and saturates.
// Optional feature macro: ACCEL_TILT_DEADZONE_EN (enables the dead zone).
//
// Ports:
//   CLK, rst_n      clock, asynchronous active-low reset
//   i_accel_x/y     raw signed samples, valid together with i_data_ready
//   i_data_ready    one-cycle sample strobe
//   i_calibrate     one-cycle request to recapture the offset (wins over a
//                   simultaneous i_data_ready, whose sample is dropped)
//   o_tilt_x/y      filtered signed tilt, held between o_valid strobes
//   o_valid         one-cycle strobe, two cycles after the sample strobe
//   o_cal_done      high while the offset is valid and filtering is running
//   o_dbg_state     current FSM state (CAL / RUN)
//
// Strobe semantics: there is no backpressure. A sample is taken on every
// cycle i_data_ready is high (back-to-back allowed); each taken RUN sample
// after the window has filled yields exactly one o_valid pulse.
// -----------------------------------------------------------------------------
module accel_tilt_filter
  import accel_pkg::*;
#(
  parameter int DATA_W   = accel_pkg::DATA_W,
  parameter int OUT_W    = accel_pkg::OUT_W,
  parameter int AVG_LOG2 = 3,
  parameter int CAL_LOG2 = 4,
  parameter int DEADZONE = 2
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_accel_x,
  input  logic signed [DATA_W-1:0] i_accel_y,
  input  logic                     i_data_ready,
  input  logic                     i_calibrate,
  output logic signed [OUT_W-1:0]  o_tilt_x,
  output logic signed [OUT_W-1:0]  o_tilt_y,
  output logic                     o_valid,
  output logic                     o_cal_done,
  output state_e                   o_dbg_state
);

  localparam logic [CAL_LOG2-1:0] CAL_LAST  = '1;
  localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2+1)'(1 << AVG_LOG2);
  localparam logic [AVG_LOG2:0]   FILL_LAST = FILL_FULL - 1'b1;

  state_e              state_q, state_d;
  logic [CAL_LOG2-1:0] cal_cnt_q, cal_cnt_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;   // saturates at a full window
  logic                load_q, load_d;
  logic                valid_q, valid_d;
  logic                cal_done_q, cal_done_d;
  logic                cal_acc, cal_last, run_acc;

  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    fill_d    = fill_q;
    cal_acc   = 1'b0;
    cal_last  = 1'b0;
    run_acc   = 1'b0;
    load_d    = 1'b0;

    if (i_calibrate) begin
      state_d   = CAL;
      cal_cnt_d = '0;
      fill_d    = '0;
    end else if (i_data_ready) begin
      case (state_q)
        CAL: begin
          cal_acc   = 1'b1;
          cal_cnt_d = cal_cnt_q + 1'b1;
          if (cal_cnt_q == CAL_LAST) begin
            cal_last = 1'b1;
            state_d  = RUN;
            fill_d   = '0;
          end
        end
        RUN: begin
          run_acc = 1'b1;
          // This sample completes (or follows) a full window.
          load_d  = (fill_q >= FILL_LAST);
          if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
        end
        default: ;
      endcase
    end

    // A calibrate arriving while an output is in flight cancels it.
    valid_d    = load_q && !i_calibrate;
    cal_done_d = (state_q == RUN) && !i_calibrate;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAL;
      cal_cnt_q  <= '0;
      fill_q     <= '0;
      load_q     <= 1'b0;
      valid_q    <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cal_cnt_q  <= cal_cnt_d;
      fill_q     <= fill_d;
      load_q     <= load_d;
      valid_q    <= valid_d;
      cal_done_q <= cal_done_d;
    end
  end

  tilt_axis_filter #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2),
    .CAL_LOG2(CAL_LOG2), .DEADZONE(DEADZONE)
  ) u_axis_x (
    .CLK(CLK), .rst_n(rst_n), .i_sample(i_accel_x), .i_calibrate(i_calibrate),
    .i_cal_acc(cal_acc), .i_cal_last(cal_last), .i_run_acc(run_acc),
    .i_load(load_q), .o_tilt(o_tilt_x)
  );

  tilt_axis_filter #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .AVG_LOG2(AVG_LOG2),
    .CAL_LOG2(CAL_LOG2), .DEADZONE(DEADZONE)
  ) u_axis_y (
    .CLK(CLK), .rst_n(rst_n), .i_sample(i_accel_y), .i_calibrate(i_calibrate),
    .i_cal_acc(cal_acc), .i_cal_last(cal_last), .i_run_acc(run_acc),
    .i_load(load_q), .o_tilt(o_tilt_y)
  );

  assign o_valid     = valid_q;
  assign o_cal_done  = cal_done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_accel_tilt_filter.sv
module tb_accel_tilt_filter;
  import accel_pkg::*;

  // ---------------- clock / reset ----------------
  logic               CLK = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [11:0] ax = '0;
  logic signed [11:0] ay = '0;
  logic               rdy = 1'b0;
  logic               cal = 1'b0;
  logic signed [7:0]  tx, ty;
  logic               vld, cdone;
  state_e             dbg;

  always #5 CLK = ~CLK;

  accel_tilt_filter dut (
    .CLK(CLK), .rst_n(rst_n),
    .i_accel_x(ax), .i_accel_y(ay),
    .i_data_ready(rdy), .i_calibrate(cal),
    .o_tilt_x(tx), .o_tilt_y(ty),
    .o_valid(vld), .o_cal_done(cdone),
    .o_dbg_state(dbg)
  );

`ifdef ACCEL_TILT_DEADZONE_EN
  localparam int DZ_ON = 1;
`else
  localparam int DZ_ON = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sample lists per phase; tilt = sat(deadzone(((mean of last 8) - offset) >>> 4)).
  bit m_run = 1'b0;
  int cal_x[$], cal_y[$], win_x[$], win_y[$];
  int off_x = 0, off_y = 0;
  bit pend = 1'b0;
  int pend_x = 0, pend_y = 0;
  bit e_valid = 1'b0, e_cd = 1'b0;
  int e_tx = 0, e_ty = 0;

  function automatic int model_tilt(input int s, input int off);
    int t;
    t = ((s >>> 3) - off) >>> 4;
    if (DZ_ON != 0 && t >= -2 && t <= 2) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  task automatic model_step();
    bit cd_next;
    if (!rst_n) begin
      m_run = 0; pend = 0; e_valid = 0; e_cd = 0; e_tx = 0; e_ty = 0;
      off_x = 0; off_y = 0;
      cal_x.delete(); cal_y.delete(); win_x.delete(); win_y.delete();
      return;
    end
    cd_next = m_run && !cal;
    if (cal) begin
      e_valid = 0; e_tx = 0; e_ty = 0;
    end else if (pend) begin
      e_valid = 1; e_tx = pend_x; e_ty = pend_y;
    end else begin
      e_valid = 0;
    end
    pend = 0;
    if (cal) begin
      m_run = 0;
      cal_x.delete(); cal_y.delete(); win_x.delete(); win_y.delete();
    end else if (rdy) begin
      if (!m_run) begin
        cal_x.push_back(int'(ax)); cal_y.push_back(int'(ay));
        if (cal_x.size() == 16) begin
          off_x = cal_x.sum() >>> 4;
          off_y = cal_y.sum() >>> 4;
          cal_x.delete(); cal_y.delete(); win_x.delete(); win_y.delete();
          m_run = 1;
        end
      end else begin
        win_x.push_back(int'(ax)); win_y.push_back(int'(ay));
        if (win_x.size() > 8) begin
          void'(win_x.pop_front()); void'(win_y.pop_front());
        end
        if (win_x.size() == 8) begin
          pend = 1;
          pend_x = model_tilt(win_x.sum(), off_x);
          pend_y = model_tilt(win_y.sum(), off_y);
        end
      end
    end
    e_cd = cd_next;
  endtask

  initial forever begin
    @(posedge CLK or negedge rst_n);
    model_step();
  end

  // ---------------- scoreboard: per-cycle compare + captured outputs ----------------
  int got_x[$], got_y[$];

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("valid", int'(vld), int'(e_valid));
      chk("cal_done", int'(cdone), int'(e_cd));
      chk("tilt_x", int'(tx), e_tx);
      chk("tilt_y", int'(ty), e_ty);
    end
    if (rst_n && vld) begin
      got_x.push_back(int'(tx));
      got_y.push_back(int'(ty));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(input int x, input int y);
    ax = 12'(x); ay = 12'(y); rdy = 1'b1;
    @(negedge CLK);
    rdy = 1'b0;
  endtask

  task automatic pulse_cal();
    cal = 1'b1;
    @(negedge CLK);
    cal = 1'b0;
  endtask

  task automatic recal(input int x, input int y);
    pulse_cal();
    for (int i = 0; i < 16; i++) begin
      send(x, y);
      idle($urandom_range(0, 1));
    end
    idle(2);
  endtask

  task automatic fill(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) begin
      send(x, y);
      idle($urandom_range(0, 1));
    end
    idle(3);
  endtask

  task automatic chk_last(input string name, input int exp);
    if (got_x.size() == 0) chk({name, "_count"}, 0, 1);
    else chk(name, got_x[got_x.size()-1], exp);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  int step_exp[8] = '{6, 12, 18, 25, 31, 37, 43, 50};

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;
    idle(3);
    chk("rst_valid", int'(vld), 0);
    chk("rst_cal_done", int'(cdone), 0);
    chk("rst_tilt_x", int'(tx), 0);
    chk("rst_tilt_y", int'(ty), 0);
    chk("rst_state", int'(dbg), int'(CAL));
    rst_n = 1'b1;
    idle(2);

    // Calibration then flat filtering
    for (int i = 0; i < 15; i++) begin send(160, -96); idle(1); end
    send(160, -96);
    chk("cal_done_n1", int'(cdone), 0);
    idle(1);
    chk("cal_done_n2", int'(cdone), 1);
    got_x.delete(); got_y.delete();
    for (int i = 0; i < 8; i++) begin send(160, -96); idle(1); end
    idle(3);
    chk("flat_valid_count", got_x.size(), 1);
    if (got_x.size() > 0) begin
      chk("flat_tilt_x", got_x[0], 0);
      chk("flat_tilt_y", got_y[0], 0);
    end

    // Saturation
    recal(0, 0);
    got_x.delete(); got_y.delete();
    fill(2047, 0, 8);
    chk_last("sat_pos", 127);
    recal(160, 0);
    got_x.delete(); got_y.delete();
    fill(-2048, 0, 8);
    chk_last("sat_neg", -128);

    // Step response
    recal(0, 0);
    fill(0, 0, 8);
    got_x.delete(); got_y.delete();
    fill(800, 0, 8);
    chk("step_count", got_x.size(), 8);
    for (int i = 0; i < 8 && i < got_x.size(); i++) chk("step_tilt_x", got_x[i], step_exp[i]);

    // Dead zone
    recal(0, 0);
    got_x.delete(); got_y.delete();
    fill(32, 0, 8);
    chk_last("dz_32", (DZ_ON != 0) ? 0 : 2);
    fill(48, 0, 8);
    chk_last("dz_48", 3);

    // Simultaneous calibrate and sample
    ax = 12'(500); ay = 12'(0); rdy = 1'b1; cal = 1'b1;
    @(negedge CLK);
    rdy = 1'b0; cal = 1'b0;
    chk("simul_valid", int'(vld), 0);
    chk("simul_tilt_x", int'(tx), 0);
    chk("simul_cal_done", int'(cdone), 0);
    for (int i = 0; i < 16; i++) begin send(0, 0); idle(1); end
    idle(2);
    chk("simul_recal_done", int'(cdone), 1);
    got_x.delete(); got_y.delete();
    fill(800, 0, 8);
    chk_last("simul_after", 50);

    // Reset while running with non-zero tilt
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run_tilt_x", int'(tx), 0);
    chk("rst_run_cal_done", int'(cdone), 0);
    @(negedge CLK) rst_n = 1'b1;
    idle(1);

    // Reset mid-calibration: the 7 early samples must be forgotten
    for (int i = 0; i < 7; i++) begin send(1000, 1000); idle(1); end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cal_valid", int'(vld), 0);
    chk("rst_cal_state", int'(dbg), int'(CAL));
    @(negedge CLK) rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) begin send(64, -64); idle(1); end
    idle(2);
    got_x.delete(); got_y.delete();
    fill(64, -64, 8);
    chk_last("rst_cal_flat", 0);
    fill(224, -64, 8);
    chk_last("rst_cal_offset", 10);

    // Randomized traffic against the model
    for (int ph = 0; ph < 8; ph++) begin
      int bx, by, steps;
      bx = int'($urandom_range(0, 3000)) - 1500;
      by = int'($urandom_range(0, 3000)) - 1500;
      pulse_cal();
      for (int i = 0; i < 16; i++) begin
        send(bx + int'($urandom_range(0, 40)) - 20, by + int'($urandom_range(0, 40)) - 20);
        idle($urandom_range(0, 2));
      end
      steps = $urandom_range(10, 40);
      for (int i = 0; i < steps; i++) begin
        int r, x, y;
        r = $urandom_range(0, 39);
        if (r < 8) begin
          x = int'($urandom_range(0, 4095)) - 2048;
          y = int'($urandom_range(0, 4095)) - 2048;
        end else begin
          x = bx + int'($urandom_range(0, 800)) - 400;
          y = by + int'($urandom_range(0, 800)) - 400;
          if (x > 2047) x = 2047;
          if (x < -2048) x = -2048;
          if (y > 2047) y = 2047;
          if (y < -2048) y = -2048;
        end
        if (r == 0) begin
          pulse_cal();
        end else if (r == 1) begin
          ax = 12'(x); ay = 12'(y); rdy = 1'b1; cal = 1'b1;
          @(negedge CLK);
          rdy = 1'b0; cal = 1'b0;
        end else begin
          send(x, y);
        end
        idle($urandom_range(0, 2));
      end
      idle(3);
    end

    idle(4);
    finish_run();
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog actual=timeout expected=finish");
    finish_run();
  end

endmodule
